regc_arb: RTL and testbench
===========================

REGC_ARB -- requirements
Module: regc_arb

Interface
REQ-001 Parameter: CNT_W, default 8, width of the per-frame write counter.
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 log_req  input  1  log stage requests regc write access; held until its burst completes.
REQ-005 dct_req  input  1  DCT add/sub stage requests regc write access.
REQ-006 delta_req  input  1  delta stage requests regc write access.
REQ-007 log_last / dct_last / delta_last  input  1 each  qualifies the requester's current word as the final word of its burst.
REQ-008 frame_clr  input  1  single-cycle pulse; clears write counter and overflow flag.
REQ-009 regc_sel  output  2  regc source select: 00 hold, 01 log, 10 addsub/DCT, 11 delta.
REQ-010 regc_we  output  1  regc load enable.
REQ-011 log_ack / dct_ack / delta_ack  output  1 each  word accepted this cycle.
REQ-012 busy  output  1  high while a grant is held.
REQ-013 wr_count  output  CNT_W  regc writes since last frame_clr.
REQ-014 err_ovf  output  1  sticky counter-saturation flag.

Function
REQ-015 The block SHALL implement two states: IDLE and XFER; all outputs SHALL be registered.
REQ-016 IDLE: regc_sel=00, regc_we=0, all acks 0, busy=0.
REQ-017 In IDLE with any req high, the block SHALL select a winner round-robin (order log -> dct -> delta -> log), starting at the rr pointer, and enter XFER next cycle.
REQ-018 XFER: regc_sel SHALL hold the winner code (01/10/11) for the entire grant; busy=1.
REQ-019 In XFER, regc_we and the winner's ack SHALL be 1 in exactly those cycles in which the winner's req is high; the acks of non-winners SHALL stay 0.
REQ-020 Latency: a req first seen high in IDLE at cycle N SHALL produce regc_we=1 and ack=1 at cycle N+1 (sampled with req still high).
REQ-021 A winner's req low in XFER (no last) SHALL stall: regc_we=0, ack=0, sel held, grant retained.
REQ-022 A winner's req and last both high in XFER SHALL complete the write that cycle; next state IDLE; rr pointer SHALL advance to the requester after the winner.
REQ-023 A last signal without the corresponding req SHALL be ignored.
REQ-024 Requests from non-winners during XFER SHALL be held pending, not dropped, and SHALL be arbitrated on the return to IDLE (one IDLE cycle between grants; regc_sel=00 in it).
REQ-025 wr_count SHALL increment by 1 on every cycle with regc_we=1, saturating at 2^CNT_W-1; an attempted increment at saturation SHALL set err_ovf.
REQ-026 frame_clr SHALL set wr_count to 0 and err_ovf to 0; if it coincides with a regc_we cycle, wr_count SHALL become 1 and err_ovf 0.
REQ-027 frame_clr SHALL NOT affect the state, grant, or rr pointer.
REQ-028 Simultaneous requests in IDLE SHALL grant exactly one requester; never two acks in one cycle.

Reset
REQ-029 rst_n=0 at a rising edge SHALL force state IDLE, rr pointer to log, regc_sel=00, regc_we=0, all acks 0, busy=0, wr_count=0, err_ovf=0.
REQ-030 Reset asserted mid-XFER SHALL abort the grant with no further regc_we; first grant after release SHALL go to log if log_req is high.

Verification
REQ-031 After reset, log_req=1 for 3 cycles with log_last on cycle 3 -> regc_sel=01 and regc_we=1 for 3 cycles starting 1 cycle after req, then regc_sel=00, wr_count=3.
REQ-032 All three reqs high continuously, each burst of 2 words -> grant order log, dct, delta, log with sel 01,10,11,01; one IDLE cycle between grants; never two acks high together.
REQ-033 dct grant, dct_req dropped for 2 cycles mid-burst -> regc_we=0 and sel=10 held for 2 cycles, burst then resumes; delta_req pending is served only after dct_last.
REQ-034 CNT_W=4, 17 single-word writes -> wr_count stops at 15, err_ovf=1 after the 16th write; frame_clr coinciding with a write -> wr_count=1, err_ovf=0.
REQ-035 rst_n low for one cycle during delta XFER -> next cycle regc_we=0, sel=00, busy=0; with log_req and delta_req both high after release -> log granted first.

Source files
------------

// File: rtl/regc_arb.sv
// Purpose : round-robin arbiter granting regc write access to the log, DCT add/sub and delta stages.
// Latency : one cycle; a request seen in IDLE is acked with regc_we on the following cycle, all outputs registered.
// Backpr. : a granted requester stalls the grant by dropping req; losing requesters stay pending until the grant ends.
//
// Ports:
//   clk, rst_n                     clock, synchronous active-low reset
//   log/dct/delta_req, *_last      per-requester request and end-of-burst qualifier
//   frame_clr                      clears wr_count and err_ovf (does not touch the grant)
//   regc_sel, regc_we              regc source select (00 hold, 01 log, 10 dct, 11 delta) and load enable
//   log/dct/delta_ack, busy        per-requester word accept, grant held
//   wr_count, err_ovf              saturating write counter since frame_clr, sticky saturation flag
module regc_arb #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             log_req,
  input  logic             dct_req,
  input  logic             delta_req,
  input  logic             log_last,
  input  logic             dct_last,
  input  logic             delta_last,
  input  logic             frame_clr,
  output logic [1:0]       regc_sel,
  output logic             regc_we,
  output logic             log_ack,
  output logic             dct_ack,
  output logic             delta_ack,
  output logic             busy,
  output logic [CNT_W-1:0] wr_count,
  output logic             err_ovf
);

  typedef enum logic {IDLE, XFER} state_t;

  state_t     state, state_nxt;
  logic [1:0] rr_ptr, rr_ptr_nxt;   // requester index: 0 log, 1 dct, 2 delta
  logic [1:0] win, win_nxt;         // index of the current grant holder
  logic       done, done_nxt;       // final word already accepted; drop grant next cycle
  logic [1:0] sel_nxt;
  logic       we_nxt;
  logic [2:0] ack_nxt;
  logic       busy_nxt;

  logic [2:0] req, last;
  logic       arb_hit;
  logic [1:0] arb_idx;
  logic [2:0] scan;

  assign req  = {delta_req, dct_req, log_req};
  assign last = {delta_last, dct_last, log_last};

  function automatic logic [1:0] after(input logic [1:0] idx);
    return (idx == 2'd2) ? 2'd0 : 2'(idx + 2'd1);
  endfunction

  // Scan from the farthest offset back to rr_ptr so the closest requester
  // to the pointer is the one left standing.
  always_comb begin
    arb_hit = 1'b0;
    arb_idx = rr_ptr;
    scan    = 3'd0;
    for (int i = 2; i >= 0; i--) begin
      scan = {1'b0, rr_ptr} + 3'(i);
      if (scan >= 3'd3) scan = scan - 3'd3;
      if (req[scan[1:0]]) begin
        arb_hit = 1'b1;
        arb_idx = scan[1:0];
      end
    end
  end

  always_comb begin
    state_nxt  = state;
    rr_ptr_nxt = rr_ptr;
    win_nxt    = win;
    done_nxt   = 1'b0;
    sel_nxt    = 2'b00;
    we_nxt     = 1'b0;
    ack_nxt    = 3'b000;
    busy_nxt   = 1'b0;
    case (state)
      IDLE: begin
        if (arb_hit) begin
          state_nxt        = XFER;
          win_nxt          = arb_idx;
          sel_nxt          = 2'(arb_idx + 2'd1);
          we_nxt           = 1'b1;
          ack_nxt[arb_idx] = 1'b1;
          busy_nxt         = 1'b1;
          if (last[arb_idx]) begin
            done_nxt   = 1'b1;
            rr_ptr_nxt = after(arb_idx);
          end
        end
      end
      XFER: begin
        if (done) begin
          // This cycle shows the last write; the following one is the mandatory
          // IDLE gap, so requests seen now are left pending.
          state_nxt = IDLE;
        end else begin
          sel_nxt  = 2'(win + 2'd1);
          busy_nxt = 1'b1;
          if (req[win]) begin
            we_nxt       = 1'b1;
            ack_nxt[win] = 1'b1;
            if (last[win]) begin
              done_nxt   = 1'b1;
              rr_ptr_nxt = after(win);
            end
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      rr_ptr    <= 2'd0;
      win       <= 2'd0;
      done      <= 1'b0;
      regc_sel  <= 2'b00;
      regc_we   <= 1'b0;
      log_ack   <= 1'b0;
      dct_ack   <= 1'b0;
      delta_ack <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_nxt;
      rr_ptr    <= rr_ptr_nxt;
      win       <= win_nxt;
      done      <= done_nxt;
      regc_sel  <= sel_nxt;
      regc_we   <= we_nxt;
      log_ack   <= ack_nxt[0];
      dct_ack   <= ack_nxt[1];
      delta_ack <= ack_nxt[2];
      busy      <= busy_nxt;
    end
  end

  // Counts the write shown on regc_we in the current cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_count <= '0;
      err_ovf  <= 1'b0;
    end else if (frame_clr) begin
      wr_count <= regc_we ? CNT_W'(1) : '0;
      err_ovf  <= 1'b0;
    end else if (regc_we) begin
      if (wr_count == {CNT_W{1'b1}}) err_ovf <= 1'b1;
      else                           wr_count <= wr_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_regc_arb.sv
module tb_regc_arb;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       log_req = 0, dct_req = 0, delta_req = 0;
  logic       log_last = 0, dct_last = 0, delta_last = 0;
  logic       frame_clr = 0;
  logic [1:0] regc_sel;
  logic       regc_we, log_ack, dct_ack, delta_ack, busy, err_ovf;
  logic [3:0] wr_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  regc_arb #(.CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .log_req(log_req), .dct_req(dct_req), .delta_req(delta_req),
    .log_last(log_last), .dct_last(dct_last), .delta_last(delta_last),
    .frame_clr(frame_clr),
    .regc_sel(regc_sel), .regc_we(regc_we),
    .log_ack(log_ack), .dct_ack(dct_ack), .delta_ack(delta_ack),
    .busy(busy), .wr_count(wr_count), .err_ovf(err_ovf)
  );

  // {sel, we, acks{delta,dct,log}, busy, wr_count, err_ovf}
  function automatic bit [11:0] outs();
    return {regc_sel, regc_we, delta_ack, dct_ack, log_ack, busy, wr_count, err_ovf};
  endfunction

  task automatic check(input string name, input bit [11:0] got, input bit [11:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got sel=%b we=%b ack=%b busy=%b cnt=%0d ovf=%b, expected sel=%b we=%b ack=%b busy=%b cnt=%0d ovf=%b",
               name, got[11:10], got[9], got[8:6], got[5], got[4:1], got[0],
               exp[11:10], exp[9], exp[8:6], exp[5], exp[4:1], exp[0]);
    end
  endtask

  task automatic check_int(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  task automatic drive(input bit r, input bit [2:0] rq, input bit [2:0] ls, input bit fc);
    rst_n = r;
    {delta_req, dct_req, log_req}    = rq;
    {delta_last, dct_last, log_last} = ls;
    frame_clr = fc;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    bit       rst_n;
    bit [2:0] req;
    bit [2:0] last;
    bit       fclr;
    bit [1:0] sel;
    bit       we;
    bit [2:0] ack;
    bit       busy;
    bit [3:0] cnt;
  } vec_t;

  function automatic vec_t mk(bit r, bit [2:0] rq, bit [2:0] ls, bit fc,
                              bit [1:0] s, bit w, bit [2:0] a, bit b, bit [3:0] c);
    vec_t v;
    v.rst_n = r; v.req = rq; v.last = ls; v.fclr = fc;
    v.sel = s; v.we = w; v.ack = a; v.busy = b; v.cnt = c;
    return v;
  endfunction

  vec_t tbl[24];

  // ---------------- behavioural reference ----------------
  int       m_own;      // -1 when nobody holds the grant
  bit       m_closing;  // owner's final word already shown
  int       m_rr;
  int       m_cnt;
  bit       m_ovf;
  bit [1:0] m_sel;
  bit       m_we, m_busy;
  bit [2:0] m_ack;

  task automatic model_step(input bit r, input bit [2:0] rq, input bit [2:0] ls, input bit fc);
    bit prev_we;
    prev_we = m_we;
    m_sel = 0; m_we = 0; m_ack = 0; m_busy = 0;
    if (!r) begin
      m_own = -1; m_closing = 0; m_rr = 0; m_cnt = 0; m_ovf = 0;
      return;
    end
    if (fc) begin
      m_cnt = prev_we ? 1 : 0;
      m_ovf = 0;
    end else if (prev_we) begin
      if (m_cnt == 15) m_ovf = 1;
      else             m_cnt = m_cnt + 1;
    end
    if (m_own < 0) begin
      for (int k = 0; k < 3; k++) begin
        int c;
        c = (m_rr + k) % 3;
        if (m_own < 0 && rq[c]) m_own = c;
      end
      if (m_own >= 0) begin
        m_sel = 2'(m_own + 1); m_we = 1; m_ack[m_own] = 1; m_busy = 1;
        if (ls[m_own]) begin m_closing = 1; m_rr = (m_own + 1) % 3; end
      end
    end else if (m_closing) begin
      m_own = -1; m_closing = 0;
    end else begin
      m_sel = 2'(m_own + 1); m_busy = 1;
      if (rq[m_own]) begin
        m_we = 1; m_ack[m_own] = 1;
        if (ls[m_own]) begin m_closing = 1; m_rr = (m_own + 1) % 3; end
      end
    end
  endtask

  initial begin
    // rst, req{dl,dc,lg}, last, fclr  ->  sel, we, ack, busy, cnt
    tbl[0]  = mk(0, 3'b000, 3'b000, 0, 2'b00, 0, 3'b000, 0, 0);
    tbl[1]  = mk(1, 3'b001, 3'b000, 0, 2'b01, 1, 3'b001, 1, 0);
    tbl[2]  = mk(1, 3'b001, 3'b000, 0, 2'b01, 1, 3'b001, 1, 1);
    tbl[3]  = mk(1, 3'b001, 3'b001, 0, 2'b01, 1, 3'b001, 1, 2);
    tbl[4]  = mk(1, 3'b000, 3'b000, 0, 2'b00, 0, 3'b000, 0, 3);
    tbl[5]  = mk(1, 3'b000, 3'b000, 0, 2'b00, 0, 3'b000, 0, 3);
    tbl[6]  = mk(1, 3'b010, 3'b000, 0, 2'b10, 1, 3'b010, 1, 3);
    tbl[7]  = mk(1, 3'b110, 3'b000, 0, 2'b10, 1, 3'b010, 1, 4);
    tbl[8]  = mk(1, 3'b100, 3'b000, 0, 2'b10, 0, 3'b000, 1, 5);
    tbl[9]  = mk(1, 3'b100, 3'b000, 0, 2'b10, 0, 3'b000, 1, 5);
    tbl[10] = mk(1, 3'b110, 3'b010, 0, 2'b10, 1, 3'b010, 1, 5);
    tbl[11] = mk(1, 3'b100, 3'b000, 0, 2'b00, 0, 3'b000, 0, 6);
    tbl[12] = mk(1, 3'b100, 3'b000, 0, 2'b11, 1, 3'b100, 1, 6);
    tbl[13] = mk(1, 3'b100, 3'b000, 0, 2'b11, 1, 3'b100, 1, 7);
    tbl[14] = mk(0, 3'b101, 3'b000, 0, 2'b00, 0, 3'b000, 0, 0);
    tbl[15] = mk(1, 3'b101, 3'b000, 0, 2'b01, 1, 3'b001, 1, 0);
    tbl[16] = mk(1, 3'b101, 3'b001, 0, 2'b01, 1, 3'b001, 1, 1);
    tbl[17] = mk(1, 3'b101, 3'b000, 0, 2'b00, 0, 3'b000, 0, 2);
    tbl[18] = mk(1, 3'b101, 3'b000, 0, 2'b11, 1, 3'b100, 1, 2);
    tbl[19] = mk(1, 3'b000, 3'b000, 0, 2'b11, 0, 3'b000, 1, 3);
    tbl[20] = mk(1, 3'b000, 3'b100, 0, 2'b11, 0, 3'b000, 1, 3);
    tbl[21] = mk(1, 3'b100, 3'b100, 0, 2'b11, 1, 3'b100, 1, 3);
    tbl[22] = mk(1, 3'b000, 3'b000, 0, 2'b00, 0, 3'b000, 0, 4);
    tbl[23] = mk(1, 3'b000, 3'b000, 1, 2'b00, 0, 3'b000, 0, 0);

    for (int i = 0; i < 24; i++) begin
      drive(tbl[i].rst_n, tbl[i].req, tbl[i].last, tbl[i].fclr);
      tick();
      check($sformatf("table[%0d]", i), outs(),
            {tbl[i].sel, tbl[i].we, tbl[i].ack, tbl[i].busy, tbl[i].cnt, 1'b0});
    end

    // ---------------- round robin with all requests held ----------------
    begin
      int       grants[$];
      int       writes[$];
      int       wcount;
      int       double_ack;
      bit [1:0] prev_sel;
      drive(0, 3'b000, 3'b000, 0);
      tick();
      prev_sel = 2'b00; wcount = 0; double_ack = 0;
      for (int c = 0; c < 20; c++) begin
        // Each requester flags its second word as last once it has seen an ack.
        drive(1, 3'b111, {delta_ack, dct_ack, log_ack}, 0);
        tick();
        if ($countones({delta_ack, dct_ack, log_ack}) > 1) double_ack++;
        if (prev_sel == 2'b00 && regc_sel != 2'b00) grants.push_back(int'(regc_sel));
        if (regc_sel != 2'b00 && regc_we) wcount++;
        if (prev_sel != 2'b00 && regc_sel == 2'b00) begin
          writes.push_back(wcount);
          wcount = 0;
        end
        prev_sel = regc_sel;
      end
      check_int("rr grant count>=4", (grants.size() >= 4) ? 1 : 0, 1);
      if (grants.size() >= 4) begin
        check_int("rr grant0 sel", grants[0], 1);
        check_int("rr grant1 sel", grants[1], 2);
        check_int("rr grant2 sel", grants[2], 3);
        check_int("rr grant3 sel", grants[3], 1);
      end
      check_int("rr burst count>=3", (writes.size() >= 3) ? 1 : 0, 1);
      foreach (writes[k]) check_int($sformatf("rr burst%0d words", k), writes[k], 2);
      check_int("rr double ack", double_ack, 0);
    end

    // ---------------- counter saturation and frame_clr ----------------
    drive(0, 3'b000, 3'b000, 0);
    tick();
    for (int e = 1; e <= 33; e++) begin
      drive(1, 3'b001, 3'b001, 0);
      tick();
      if (e == 2)  check_int("sat cnt after 1 write", int'(wr_count), 1);
      if (e == 30) check_int("sat cnt after 15 writes", int'({wr_count, err_ovf}), 30);
      if (e == 32) check_int("sat cnt/ovf after 16 writes", int'({wr_count, err_ovf}), 31);
    end
    check_int("17th write visible", int'(regc_we), 1);
    drive(1, 3'b000, 3'b000, 1);
    tick();
    check_int("frame_clr with write cnt", int'(wr_count), 1);
    check_int("frame_clr with write ovf", int'(err_ovf), 0);

    // ---------------- randomized vs reference model ----------------
    drive(0, 3'b000, 3'b000, 0);
    model_step(0, 3'b000, 3'b000, 0);
    tick();
    check("rand reset", outs(), {m_sel, m_we, m_ack, m_busy, 4'(m_cnt), m_ovf});
    for (int c = 0; c < 600; c++) begin
      bit       r, fc;
      bit [2:0] rq, ls;
      r  = ($urandom_range(0, 49) != 0);
      fc = ($urandom_range(0, 19) == 0);
      for (int b = 0; b < 3; b++) begin
        rq[b] = ($urandom_range(0, 3) != 0);
        ls[b] = ($urandom_range(0, 2) == 0);
      end
      drive(r, rq, ls, fc);
      model_step(r, rq, ls, fc);
      tick();
      check($sformatf("rand cycle %0d", c), outs(), {m_sel, m_we, m_ack, m_busy, 4'(m_cnt), m_ovf});
      if ($countones({delta_ack, dct_ack, log_ack}) > 1) begin
        check_int($sformatf("rand one-ack cycle %0d", c), $countones({delta_ack, dct_ack, log_ack}), 1);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
